// File: rtl/mc_pkg.sv
// Shared constants for the multicycle MIPS control unit: FSM states,
// opcode/funct encodings and ALU control codes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BEQEX  = 4'd8,
    S_IEX    = 4'd9,
    S_IWB    = 4'd10,
    S_JEX    = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;

  function automatic logic isLegalOp(logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// R-type funct field to ALU control decoder; unknown functs fall back to ADD.
module mc_aludec
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] aluctrl
);

  always_comb begin
    case (funct)
      FN_ADD:  aluctrl = ALU_ADD;
      FN_SUB:  aluctrl = ALU_SUB;
      FN_AND:  aluctrl = ALU_AND;
      FN_OR:   aluctrl = ALU_OR;
      FN_SLT:  aluctrl = ALU_SLT;
      FN_NOR:  aluctrl = ALU_NOR;
      FN_SLL:  aluctrl = ALU_SLL;
      FN_SRL:  aluctrl = ALU_SRL;
      default: aluctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Moore control FSM for a multicycle MIPS subset datapath with memory
// wait states driven by memready.
module mc_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       memready,
  output logic       memtoreg,
  output logic       alusrca,
  output logic       regdst,
  output logic       regwrite,
  output logic       signext,
  output logic       jump,
  output logic       branch,
  output logic       pcwritecond,
  output logic       pcwrite,
  output logic       memwrite,
  output logic       irwrite,
  output logic       iord,
  output logic       illegal,
  output logic [1:0] pcsrc,
  output logic [1:0] alusrcb,
  output logic [3:0] aluctrl,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  logic [3:0] rtAluctrl;

  mc_aludec u_aludec (
    .funct  (funct),
    .aluctrl(rtAluctrl)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (memready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:                state_d = S_MEMADR;
          OP_RTYPE:                    state_d = S_RTEX;
          OP_BEQ:                      state_d = S_BEQEX;
          OP_ADDI, OP_ANDI, OP_ORI:    state_d = S_IEX;
          OP_J:                        state_d = S_JEX;
          default:                     state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (memready) state_d = S_MEMWB;
      S_MEMWR:  if (memready) state_d = S_FETCH;
      S_RTEX:   state_d = S_RTWB;
      S_IEX:    state_d = S_IWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Outputs depend only on state, except the memready-gated fetch strobes
  // and the op-dependent immediate ALU selection.
  always_comb begin
    memtoreg    = 1'b0;
    alusrca     = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    jump        = 1'b0;
    branch      = 1'b0;
    pcwritecond = 1'b0;
    pcwrite     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    iord        = 1'b0;
    illegal     = 1'b0;
    pcsrc       = 2'b00;
    alusrcb     = 2'b00;
    aluctrl     = ALU_AND;
    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        aluctrl = ALU_ADD;
        pcsrc   = 2'b01;
        irwrite = memready;
        pcwrite = memready;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        aluctrl = ALU_ADD;
        illegal = !isLegalOp(op);
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluctrl = ALU_ADD;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_RTEX: begin
        alusrca = 1'b1;
        aluctrl = rtAluctrl;
      end
      S_RTWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX: begin
        alusrca     = 1'b1;
        aluctrl     = ALU_SUB;
        pcwritecond = 1'b1;
        branch      = 1'b1;
      end
      S_IEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        case (op)
          OP_ANDI: aluctrl = ALU_AND;
          OP_ORI:  aluctrl = ALU_OR;
          default: aluctrl = ALU_ADD;
        endcase
      end
      S_IWB: regwrite = 1'b1;
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        jump    = 1'b1;
      end
      default: ;
    endcase
  end

  assign signext = !((op == OP_ANDI) || (op == OP_ORI));
  assign state   = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: each stimulus cycle queues its expected
// outputs, and a negedge monitor pops and compares them.
module tb_mc_control;

  typedef struct packed {
    logic [3:0] state;
    logic       memtoreg, alusrca, regdst, regwrite, signext;
    logic       jump, branch, pcwritecond, pcwrite;
    logic       memwrite, irwrite, iord, illegal;
    logic [1:0] pcsrc, alusrcb;
    logic [3:0] aluctrl;
  } exp_t;

  logic clk, reset, memready;
  logic [5:0] op, funct;
  logic memtoreg, alusrca, regdst, regwrite, signext, jump, branch;
  logic pcwritecond, pcwrite, memwrite, irwrite, iord, illegal;
  logic [1:0] pcsrc, alusrcb;
  logic [3:0] aluctrl, state;

  exp_t  expQ[$];
  string nameQ[$];
  int    checks = 0;
  int    errors = 0;

  mc_control dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .memready(memready),
    .memtoreg(memtoreg), .alusrca(alusrca), .regdst(regdst), .regwrite(regwrite),
    .signext(signext), .jump(jump), .branch(branch), .pcwritecond(pcwritecond),
    .pcwrite(pcwrite), .memwrite(memwrite), .irwrite(irwrite), .iord(iord),
    .illegal(illegal), .pcsrc(pcsrc), .alusrcb(alusrcb), .aluctrl(aluctrl),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected per-state output tables, written out by hand.
  function automatic exp_t eBase(logic [3:0] s, logic sx);
    exp_t e;
    e = '0;
    e.state = s;
    e.signext = sx;
    return e;
  endfunction
  function automatic exp_t eFetch(logic mr, logic sx);
    exp_t e;
    e = eBase(4'd0, sx);
    e.alusrcb = 2'b01; e.aluctrl = 4'b0010; e.pcsrc = 2'b01;
    e.irwrite = mr; e.pcwrite = mr;
    return e;
  endfunction
  function automatic exp_t eDecode(logic sx, logic ill);
    exp_t e;
    e = eBase(4'd1, sx);
    e.alusrcb = 2'b11; e.aluctrl = 4'b0010; e.illegal = ill;
    return e;
  endfunction
  function automatic exp_t eMemAdr(logic sx);
    exp_t e;
    e = eBase(4'd2, sx);
    e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluctrl = 4'b0010;
    return e;
  endfunction
  function automatic exp_t eMemRd();
    exp_t e;
    e = eBase(4'd3, 1'b1);
    e.iord = 1'b1;
    return e;
  endfunction
  function automatic exp_t eMemWb();
    exp_t e;
    e = eBase(4'd4, 1'b1);
    e.memtoreg = 1'b1; e.regwrite = 1'b1;
    return e;
  endfunction
  function automatic exp_t eMemWr();
    exp_t e;
    e = eBase(4'd5, 1'b1);
    e.iord = 1'b1; e.memwrite = 1'b1;
    return e;
  endfunction
  function automatic exp_t eRtEx(logic [3:0] alu);
    exp_t e;
    e = eBase(4'd6, 1'b1);
    e.alusrca = 1'b1; e.alusrcb = 2'b00; e.aluctrl = alu;
    return e;
  endfunction
  function automatic exp_t eRtWb();
    exp_t e;
    e = eBase(4'd7, 1'b1);
    e.regdst = 1'b1; e.regwrite = 1'b1;
    return e;
  endfunction
  function automatic exp_t eBeqEx();
    exp_t e;
    e = eBase(4'd8, 1'b1);
    e.alusrca = 1'b1; e.aluctrl = 4'b0110; e.pcsrc = 2'b00;
    e.pcwritecond = 1'b1; e.branch = 1'b1;
    return e;
  endfunction
  function automatic exp_t eIEx(logic sx, logic [3:0] alu);
    exp_t e;
    e = eBase(4'd9, sx);
    e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluctrl = alu;
    return e;
  endfunction
  function automatic exp_t eIWb(logic sx);
    exp_t e;
    e = eBase(4'd10, sx);
    e.regwrite = 1'b1;
    return e;
  endfunction
  function automatic exp_t eJEx();
    exp_t e;
    e = eBase(4'd11, 1'b1);
    e.pcsrc = 2'b10; e.pcwrite = 1'b1; e.jump = 1'b1;
    return e;
  endfunction

  // Drives one cycle's inputs just after the rising edge and queues the
  // outputs expected for that cycle.
  task automatic applyStimulus(input logic rst, input logic mr, input logic [5:0] o,
                               input logic [5:0] f, input exp_t e, input string name);
    @(posedge clk);
    #1;
    reset = rst; memready = mr; op = o; funct = f;
    expQ.push_back(e);
    nameQ.push_back(name);
  endtask

  task automatic checkOutput();
    exp_t  e, a;
    string n;
    e = expQ.pop_front();
    n = nameQ.pop_front();
    a = {state, memtoreg, alusrca, regdst, regwrite, signext, jump, branch,
         pcwritecond, pcwrite, memwrite, irwrite, iord, illegal, pcsrc, alusrcb, aluctrl};
    checks++;
    if (a !== e) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (state got %0d expected %0d)",
               n, a, e, a.state, e.state);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput();
  end

  task automatic runR(input logic [5:0] f, input logic [3:0] alu, input string name);
    applyStimulus(1, 1, 6'b000000, f, eFetch(1, 1), {name, " fetch"});
    applyStimulus(1, 1, 6'b000000, f, eDecode(1, 0), {name, " decode"});
    applyStimulus(1, 1, 6'b000000, f, eRtEx(alu), {name, " rtex"});
    applyStimulus(1, 1, 6'b000000, f, eRtWb(), {name, " rtwb"});
  endtask

  task automatic runI(input logic [5:0] o, input logic sx, input logic [3:0] alu,
                      input string name);
    applyStimulus(1, 1, o, 6'd0, eFetch(1, sx), {name, " fetch"});
    applyStimulus(1, 1, o, 6'd0, eDecode(sx, 0), {name, " decode"});
    applyStimulus(1, 1, o, 6'd0, eIEx(sx, alu), {name, " iex"});
    applyStimulus(1, 1, o, 6'd0, eIWb(sx), {name, " iwb"});
  endtask

  initial begin
    reset = 1'b0; memready = 1'b0; op = 6'd0; funct = 6'd0;

    applyStimulus(0, 0, 6'd0, 6'd0, eFetch(0, 1), "reset mr0");
    applyStimulus(0, 1, 6'd0, 6'd0, eFetch(1, 1), "reset mr1");
    applyStimulus(1, 0, 6'd0, 6'd0, eFetch(0, 1), "reset release");

    runR(6'b100000, 4'b0010, "add");
    runR(6'b100010, 4'b0110, "sub");
    runR(6'b101010, 4'b0111, "slt");
    runR(6'b100111, 4'b1100, "nor");
    runR(6'b000000, 4'b1000, "sll");
    runR(6'b000010, 4'b1001, "srl");
    runR(6'b100100, 4'b0000, "and");
    runR(6'b100101, 4'b0001, "or");
    runR(6'b111111, 4'b0010, "unknown funct");

    applyStimulus(1, 1, 6'b100011, 6'd0, eFetch(1, 1), "lw fetch");
    applyStimulus(1, 1, 6'b100011, 6'd0, eDecode(1, 0), "lw decode");
    applyStimulus(1, 1, 6'b100011, 6'd0, eMemAdr(1), "lw memadr");
    applyStimulus(1, 0, 6'b100011, 6'd0, eMemRd(), "lw memrd wait1");
    applyStimulus(1, 0, 6'b100011, 6'd0, eMemRd(), "lw memrd wait2");
    applyStimulus(1, 1, 6'b100011, 6'd0, eMemRd(), "lw memrd ready");
    applyStimulus(1, 1, 6'b100011, 6'd0, eMemWb(), "lw memwb");

    applyStimulus(1, 1, 6'b000100, 6'd0, eFetch(1, 1), "beq fetch");
    applyStimulus(1, 1, 6'b000100, 6'd0, eDecode(1, 0), "beq decode");
    applyStimulus(1, 1, 6'b000100, 6'd0, eBeqEx(), "beq beqex");

    runI(6'b001101, 1'b0, 4'b0001, "ori");
    runI(6'b001000, 1'b1, 4'b0010, "addi");
    runI(6'b001100, 1'b0, 4'b0000, "andi");

    applyStimulus(1, 0, 6'b000010, 6'd0, eFetch(0, 1), "j fetch wait1");
    applyStimulus(1, 0, 6'b000010, 6'd0, eFetch(0, 1), "j fetch wait2");
    applyStimulus(1, 1, 6'b000010, 6'd0, eFetch(1, 1), "j fetch ready");
    applyStimulus(1, 1, 6'b000010, 6'd0, eDecode(1, 0), "j decode");
    applyStimulus(1, 1, 6'b000010, 6'd0, eJEx(), "j jex");

    applyStimulus(1, 1, 6'b111111, 6'd0, eFetch(1, 1), "illegal fetch");
    applyStimulus(1, 1, 6'b111111, 6'd0, eDecode(1, 1), "illegal decode");
    applyStimulus(1, 0, 6'b111111, 6'd0, eFetch(0, 1), "illegal refetch1");
    applyStimulus(1, 0, 6'b111111, 6'd0, eFetch(0, 1), "illegal refetch2");

    applyStimulus(1, 1, 6'b101011, 6'd0, eFetch(1, 1), "sw fetch");
    applyStimulus(1, 1, 6'b101011, 6'd0, eDecode(1, 0), "sw decode");
    applyStimulus(1, 1, 6'b101011, 6'd0, eMemAdr(1), "sw memadr");
    applyStimulus(1, 0, 6'b101011, 6'd0, eMemWr(), "sw memwr wait");
    applyStimulus(1, 1, 6'b101011, 6'd0, eMemWr(), "sw memwr ready");

    applyStimulus(1, 1, 6'b101011, 6'd0, eFetch(1, 1), "sw2 fetch");
    applyStimulus(1, 1, 6'b101011, 6'd0, eDecode(1, 0), "sw2 decode");
    applyStimulus(1, 1, 6'b101011, 6'd0, eMemAdr(1), "sw2 memadr");
    applyStimulus(1, 0, 6'b101011, 6'd0, eMemWr(), "sw2 memwr");
    applyStimulus(0, 0, 6'b101011, 6'd0, eFetch(0, 1), "sw2 reset abort");
    applyStimulus(0, 1, 6'b101011, 6'd0, eFetch(1, 1), "sw2 reset held");
    applyStimulus(1, 0, 6'b101011, 6'd0, eFetch(0, 1), "sw2 after reset");

    repeat (3) @(posedge clk);
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have inputs op[5:0] (instr[31:26]), funct[5:0] (instr[5:0]) and memready (1 = memory access completes this cycle).
REQ-004 SHALL have 1-bit outputs:
- memtoreg, alusrca, regdst, regwrite, signext: datapath controls.
- jump, branch, pcwritecond, pcwrite: PC controls.
- memwrite, irwrite, iord: memory and IR controls.
- illegal: unsupported opcode flag.
REQ-005 SHALL have outputs pcsrc[1:0] (00 aluout, 01 aluresult, 10 jump target), alusrcb[1:0] (00 regB, 01 const 4, 10 signimm, 11 signimm<<2), aluctrl[3:0] and state[3:0] (debug).

Function
REQ-006 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEX, RTWB, BEQEX, IEX, IWB and JEX; every output not listed for a state SHALL be 0.
REQ-007 FETCH SHALL drive iord=0, alusrca=0, alusrcb=01, aluctrl=ADD and pcsrc=01.
- irwrite=1 and pcwrite=1 only in a cycle where memready=1; the FSM then moves to DECODE, otherwise it holds in FETCH.
REQ-008 DECODE SHALL drive alusrca=0, alusrcb=11 and aluctrl=ADD (branch target into aluout), then move on op:
- lw/sw -> MEMADR; R-type -> RTEX; beq -> BEQEX.
- addi/andi/ori -> IEX; j -> JEX.
- any other op -> FETCH with illegal=1 for that cycle.
REQ-009 MEMADR SHALL drive alusrca=1, alusrcb=10 and aluctrl=ADD, then move to MEMRD (lw) or MEMWR (sw).
REQ-010 MEMRD SHALL drive iord=1 and hold until memready=1, then move to MEMWB.
REQ-011 MEMWB SHALL drive regdst=0, memtoreg=1 and regwrite=1, then move to FETCH.
REQ-012 MEMWR SHALL drive iord=1 and memwrite=1, hold until memready=1, then move to FETCH.
REQ-013 RTEX SHALL drive alusrca=1, alusrcb=00 and aluctrl=funct decode, then move to RTWB.
REQ-014 RTWB SHALL drive regdst=1, memtoreg=0 and regwrite=1, then move to FETCH.
REQ-015 BEQEX SHALL drive alusrca=1, alusrcb=00, aluctrl=SUB, pcsrc=00, pcwritecond=1 and branch=1, then move to FETCH.
REQ-016 IEX SHALL drive alusrca=1 and alusrcb=10, with aluctrl ADD for addi, AND for andi and OR for ori, then move to IWB.
REQ-017 IWB SHALL drive regdst=0, memtoreg=0 and regwrite=1, then move to FETCH.
REQ-018 JEX SHALL drive pcsrc=10, pcwrite=1 and jump=1, then move to FETCH.
REQ-019 signext SHALL be 0 when op is andi/ori and 1 otherwise, independent of state.
REQ-020 Opcodes SHALL be: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, andi=001100, ori=001101, j=000010.
REQ-021 aluctrl encodings SHALL be AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, NOR=1100, SLL=1000, SRL=1001.
REQ-022 funct decode SHALL map 100000->ADD, 100010->SUB, 100100->AND, 100101->OR, 101010->SLT, 100111->NOR, 000000->SLL, 000010->SRL and any other funct->ADD.
REQ-023 Latencies with memready held at 1 SHALL be: j/beq 3 cycles; R-type/addi/andi/ori/sw 4 cycles; lw 5 cycles.
REQ-024 Wait states SHALL extend FETCH, MEMRD and MEMWR by exactly the number of memready=0 cycles, with outputs stable while waiting.

Reset
REQ-025 reset=0 SHALL immediately force state=FETCH; all outputs then take their FETCH values, with pcwrite/irwrite following memready.
REQ-026 Reset asserted mid-instruction (e.g. during MEMWR) SHALL abort the instruction with no further regwrite or memwrite.

Structure
REQ-027 State, opcode, funct and aluctrl constants SHALL live in shared package mc_pkg.
REQ-028 funct->aluctrl decoding SHALL be sub-module mc_aludec; the FSM SHALL be a single state register plus next-state and output logic.

Verification
REQ-029 add (op=000000, funct=100000), memready=1 -> states FETCH, DECODE, RTEX, RTWB; regdst=1 and regwrite=1 in cycle 4 only.
REQ-030 lw (100011), memready low 2 cycles in MEMRD -> 7 cycles total; memtoreg=1 and regwrite=1 in the last cycle only.
REQ-031 beq (000100) -> BEQEX drives aluctrl=0110, pcwritecond=1, pcsrc=00; next state FETCH.
REQ-032 ori (001101) -> signext=0 throughout; aluctrl=0001 in IEX; regwrite=1 in IWB.
REQ-033 op=111111 -> illegal=1 for one DECODE cycle, then FETCH; no regwrite, memwrite or pcwrite after the FETCH cycle.
REQ-034 sw with reset pulsed low in MEMWR -> state=FETCH at once, memwrite=0 while reset is low.
